// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } pipe_state_e;

  localparam int unsigned DEF_MC_LAT = 4;
  localparam int unsigned DEF_CNT_W  = 32;

  // Width of the multi-cycle latency down-counter for a given latency.
  function automatic int unsigned mc_cnt_w(input int unsigned lat);
    return $clog2(lat) + 1;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/branch/memory inputs and register-bank controls of the stall sequencer.
interface pipe_stall_ctrl_if import pipe_ctrl_pkg::*; #(
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             load_use;
  logic             br_taken;
  logic             mc_start;
  logic             mem_wait;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             busy;
  logic             mc_done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output load_use, br_taken, mc_start, mem_wait,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
    input  busy, mc_done, stall_cnt
  );

  modport slave (
    input  load_use, br_taken, mc_start, mem_wait,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
    output busy, mc_done, stall_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// Saturating event counter with synchronous active-low clear.
module stall_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr_b_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr_b_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with multi-cycle EX sequencing.
module pipe_stall_ctrl import pipe_ctrl_pkg::*; #(
  parameter int unsigned MC_LAT = DEF_MC_LAT,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stall_ctrl_if.slave  bus
);
  localparam int unsigned MC_W = mc_cnt_w(MC_LAT);

  pipe_state_e     state_q, state_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic            pc_en, ifid_en, idex_en, exmem_en;
  logic            ifid_flush, idex_bubble, busy, mc_done;

  always_comb begin
    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    busy        = 1'b0;
    mc_done     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.mem_wait) begin
          state_d = RUN;
        end else if (bus.br_taken) begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'hF;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (bus.mc_start) begin
          // A single-cycle "multi-cycle" op completes in its start cycle.
          if (MC_LAT == 1) begin
            mc_done = 1'b1;
            {pc_en, ifid_en, idex_en, exmem_en} = 4'hF;
          end else begin
            mc_cnt_d = MC_W'(MC_LAT - 1);
            state_d  = MC_WAIT;
          end
        end else if (bus.load_use) begin
          idex_bubble = 1'b1;
          idex_en     = 1'b1;
          exmem_en    = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'hF;
        end
      end
      MC_WAIT: begin
        busy = 1'b1;
        if (mc_cnt_q != '0) begin
          mc_cnt_d = mc_cnt_q - MC_W'(1);
        end else if (!bus.mem_wait) begin
          mc_done = 1'b1;
          {pc_en, ifid_en, idex_en, exmem_en} = 4'hF;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (!reset) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'h0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      busy        = 1'b0;
      mc_done     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  stall_perf_cnt #(.W(CNT_W)) u_perf (
    .clk     (clk),
    .clr_b_i (reset),
    .inc_i   (~pc_en),
    .cnt_o   (bus.stall_cnt)
  );

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.busy        = busy;
  assign bus.mc_done     = mc_done;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized + directed bench for pipe_stall_ctrl against a cycle-age reference model.
module tb_pipe_stall_ctrl;
  logic clk;
  logic reset;

  int n_cmp;
  int n_bad;

  pipe_stall_ctrl_if #(.CNT_W(32)) bus_a ();
  pipe_stall_ctrl_if #(.CNT_W(3))  bus_b ();

  pipe_stall_ctrl #(.MC_LAT(4), .CNT_W(32)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  pipe_stall_ctrl #(.MC_LAT(1), .CNT_W(3)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state per DUT: age = cycles since a multi-cycle op started (0 = none).
  int      lat [2] = '{4, 1};
  longint  cmax[2] = '{64'hFFFF_FFFF, 64'd7};
  int      age [2];
  longint  cnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {pc,ifid,idex,exmem,flush,bubble,busy,done}.
  function automatic logic [7:0] model_out(input int l, input int a, input bit rst_b,
                                           input bit lw, input bit bt, input bit ms,
                                           input bit mw);
    if (!rst_b) return 8'h00;
    if (a > 0) begin
      if (a >= l && !mw) return 8'b1111_0011;
      return 8'b0000_0010;
    end
    if (mw) return 8'h00;
    if (bt) return 8'b1111_1100;
    if (ms) return (l == 1) ? 8'b1111_0001 : 8'h00;
    if (lw) return 8'b0011_0100;
    return 8'b1111_0000;
  endfunction

  task automatic step(input bit rst_b, input bit lw, input bit bt, input bit ms, input bit mw);
    logic [7:0] exp_v[2];
    logic [7:0] got_v[2];
    @(negedge clk);
    reset = rst_b;
    bus_a.load_use = lw; bus_a.br_taken = bt; bus_a.mc_start = ms; bus_a.mem_wait = mw;
    bus_b.load_use = lw; bus_b.br_taken = bt; bus_b.mc_start = ms; bus_b.mem_wait = mw;
    #2;
    got_v[0] = {bus_a.pc_en, bus_a.ifid_en, bus_a.idex_en, bus_a.exmem_en,
                bus_a.ifid_flush, bus_a.idex_bubble, bus_a.busy, bus_a.mc_done};
    got_v[1] = {bus_b.pc_en, bus_b.ifid_en, bus_b.idex_en, bus_b.exmem_en,
                bus_b.ifid_flush, bus_b.idex_bubble, bus_b.busy, bus_b.mc_done};
    for (int d = 0; d < 2; d++) exp_v[d] = model_out(lat[d], age[d], rst_b, lw, bt, ms, mw);
    check("ctl_lat4", {24'd0, got_v[0]}, {24'd0, exp_v[0]});
    check("ctl_lat1", {24'd0, got_v[1]}, {24'd0, exp_v[1]});
    check("cnt_w32", bus_a.stall_cnt, cnt[0][31:0]);
    check("cnt_w3", {29'd0, bus_b.stall_cnt}, cnt[1][31:0]);
    for (int d = 0; d < 2; d++) begin
      if (!rst_b) begin
        age[d] = 0;
        cnt[d] = 0;
      end else begin
        if (!exp_v[d][7] && cnt[d] < cmax[d]) cnt[d]++;
        if (age[d] > 0) age[d] = exp_v[d][0] ? 0 : age[d] + 1;
        else if (ms && !mw && !bt && lat[d] > 1) age[d] = 1;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    age = '{0, 0};
    cnt = '{0, 0};
    reset = 1'b0;
    bus_a.load_use = 0; bus_a.br_taken = 0; bus_a.mc_start = 0; bus_a.mem_wait = 0;
    bus_b.load_use = 0; bus_b.br_taken = 0; bus_b.mc_start = 0; bus_b.mem_wait = 0;

    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0); repeat (5) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0); step(1, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 1);
    repeat (2) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0); step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1); step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0); step(1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0); repeat (2) step(1, 0, 0, 0, 0);
    repeat (9) step(1, 0, 0, 0, 1);
    repeat (2) step(1, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Drives the write enables of the PC, IF/ID, ID/EX and EX/MEM register banks, and the IF/ID flush and ID/EX bubble controls. Decisions come from hazard, branch, memory-wait and multi-cycle-execute inputs. It also sequences multi-cycle EX operations with a latency counter and keeps a saturating stall-cycle performance counter.

## Interface
- MC_LAT, 4: cycles a multi-cycle EX op occupies EX (≥1).
- CNT_W, 32: width of the stall performance counter.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- load_use  in  1  load-use hazard detected in ID.
- br_taken  in  1  taken branch/jump resolved in EX.
- mc_start  in  1  multi-cycle op entering EX this cycle.
- mem_wait  in  1  data memory not ready; freeze whole pipe.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register-bank write enables.
- ifid_flush  out  1  IF/ID loads NOP next edge.
- idex_bubble  out  1  ID/EX loads NOP next edge.
- busy  out  1  multi-cycle op in progress.
- mc_done  out  1  one-cycle pulse on the final multi-cycle cycle.
- stall_cnt  out  CNT_W  cycles with pc_en=0 since reset.

## Operation
- FSM states: RUN, MC_WAIT. Down-counter mc_cnt, width $clog2(MC_LAT)+1.
- Outputs are Mealy: a function of state and current-cycle inputs, so stalls take effect at the next edge.
- RUN, priority mem_wait > br_taken > mc_start > load_use:
  - mem_wait: all four en=0; flush/bubble=0; stay in RUN.
  - br_taken: all en=1; ifid_flush=1; idex_bubble=1; stay in RUN. A simultaneous mc_start is dropped because the op is squashed.
  - mc_start: pc_en=ifid_en=idex_en=0; exmem_en=0; mc_cnt←MC_LAT-1; go to MC_WAIT. If MC_LAT=1, go directly to the done behaviour: mc_done=1, all en=1, stay in RUN.
  - load_use: pc_en=ifid_en=0; idex_bubble=1; idex_en=exmem_en=1; stay in RUN.
  - otherwise: all en=1.
- MC_WAIT:
  - busy=1.
  - mc_cnt decrements every cycle while nonzero, regardless of mem_wait.
  - While mc_cnt≠0: all en=0.
  - mc_cnt=0 with mem_wait=0: mc_done=1, all en=1, go to RUN.
  - mc_cnt=0 with mem_wait=1: hold with all en=0 until mem_wait drops.
  - br_taken, load_use and mc_start are ignored in MC_WAIT.
- stall_cnt increments on every edge where pc_en=0 and reset=1. It saturates at all-ones.
- Reset (reset=0 at edge): state←RUN, mc_cnt←0, stall_cnt←0.
- While reset is low, outputs are forced: all en=0, flush/bubble=0, busy=0, mc_done=0.
- Reset mid-MC_WAIT aborts the op without a mc_done pulse.

## Timing
- Output reset values: en 0, ifid_flush 0, idex_bubble 0, busy 0, mc_done 0, stall_cnt 0.
- Stall/flush latency is 0 cycles combinational from input to control; the effect lands at the next edge.
- A mc_start cycle followed by MC_WAIT gives MC_LAT stalled cycles for PC, including the start cycle. The done cycle is the MC_LAT+1-th cycle when mem_wait=0.
- busy rises the edge after mc_start and falls the edge after mc_done.
- No combinational path from any output back to any input.

## Structure
- pipe_ctrl_pkg holds:
  - the state enum {RUN, MC_WAIT};
  - the default MC_LAT;
  - a localparam for the counter width.
- One sub-module, stall_perf_cnt: a parameterised saturating counter with synchronous active-low clear and increment enable, used for stall_cnt.
- FSM and mc_cnt live in the top module.

## Test plan
- Reset, then idle for 3 cycles → all en=1, flush/bubble=0, stall_cnt=0.
- One cycle of load_use → that cycle pc_en=ifid_en=0 and idex_bubble=1; next cycle all en=1; stall_cnt=1.
- mc_start with MC_LAT=4 and no mem_wait:
  - busy=1 for 4 cycles;
  - all en=0 for cycles 0–3;
  - mc_done and all en=1 on cycle 4;
  - stall_cnt=4.
- mc_start, then mem_wait high from cycle 2 to 6 → mc_done on cycle 7, not earlier; en stays 0 through cycle 6.
- br_taken and mc_start in the same cycle → ifid_flush=idex_bubble=1; state stays RUN; busy stays 0. br_taken with mem_wait → freeze only, no flush.
- reset asserted in MC_WAIT cycle 2 → next cycle state RUN, busy=0, stall_cnt=0, no mc_done. Saturation check with CNT_W=3: 9 stall cycles → stall_cnt=7.
